// File: rtl/keyled_seg_pkg.sv
// rtl/keyled_seg_pkg.sv - shared constants, state type and hex font for the segment scanner
// Contents: register word addresses, CTRL bit positions, scan FSM state enum,
//           16-entry active-high gfedcba hex decode table.
package keyled_seg_pkg;

    localparam logic [2:0] ADDR_DIGIT0 = 3'd0;
    localparam logic [2:0] ADDR_CTRL   = 3'd4;
    localparam logic [2:0] ADDR_BLANK  = 3'd5;
    localparam logic [2:0] ADDR_STATUS = 3'd6;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_RAW = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DEAD = 2'd1,
        ST_ON   = 2'd2
    } state_t;

    // Active-high gfedcba patterns for 0..F (lowercase b and d shapes).
    localparam logic [6:0] HEX_SEG [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/keyled_seg_scan_if.sv
// rtl/keyled_seg_scan_if.sv - Avalon-MM register bus bundle for the segment scanner
// Signals: address[2:0], chipselect, write_n (active-low strobe), writedata[31:0],
//          readdata[31:0] (combinational, zero wait states).
// Modports: master drives the request side, slave returns readdata.
interface keyled_seg_scan_if;

    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/keyled_seg_hexdec.sv
// rtl/keyled_seg_hexdec.sv - combinational hex/raw to active-high segment decoder
// Ports:
//   i_value[7:0] : digit register; [3:0] hex nibble, [6:0] raw segments, [7] dp
//   i_raw        : 1 selects i_value[6:0] as-is instead of the hex font
//   o_seg[7:0]   : active-high {dp,g,f,e,d,c,b,a}; the caller inverts for the pins
module keyled_seg_hexdec
    import keyled_seg_pkg::*;
(
    input  logic [7:0] i_value,
    input  logic       i_raw,
    output logic [7:0] o_seg
);

    logic [6:0] w_font;

    assign w_font = HEX_SEG[i_value[3:0]];
    assign o_seg  = {i_value[7], (i_raw ? i_value[6:0] : w_font)};

endmodule

// File: rtl/keyled_seg_scan.sv
// rtl/keyled_seg_scan.sv - multiplexed seven-segment scan controller with Avalon-MM registers
// Ports:
//   clk, reset_n : system clock, asynchronous active-low reset
//   bus          : Avalon-MM slave (word address, chipselect, write_n, writedata, readdata)
//   seg_n[7:0]   : shared segment bus {dp,g,f,e,d,c,b,a}, active-low, registered
//   dig_n        : per-digit enables, active-low, registered; bit i drives digit i
module keyled_seg_scan
    import keyled_seg_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000,
    parameter int DEAD_CYC = 500
) (
    input  logic                clk,
    input  logic                reset_n,
    keyled_seg_scan_if.slave    bus,
    output logic [7:0]          seg_n,
    output logic [DIGITS-1:0]   dig_n
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYC - 1);
    localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [1:0]    IDX_LAST  = 2'(DIGITS - 1);

    logic [7:0]        r_digit [DIGITS];
    logic [1:0]        r_ctrl;
    logic [DIGITS-1:0] r_blank;

    state_t            r_state, w_state_nxt;
    logic [CW-1:0]     r_cnt, w_cnt_nxt;
    logic [1:0]        r_idx, w_idx_nxt;

    logic [7:0]        r_seg_n, w_seg_n_nxt;
    logic [DIGITS-1:0] r_dig_n, w_dig_n_nxt;

    logic              w_wr;
    logic              w_en;
    logic [7:0]        w_disp;
    logic              w_disp_blank;
    logic [7:0]        w_seg;
    logic [31:0]       w_rdata;

    assign w_wr = bus.chipselect && !bus.write_n;
    assign w_en = r_ctrl[CTRL_EN];

    // Register file
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DIGITS; i++) begin
                r_digit[i] <= 8'h00;
            end
            r_ctrl  <= 2'b00;
            r_blank <= '0;
        end else if (w_wr) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (bus.address == ADDR_DIGIT0 + 3'(i)) begin
                    r_digit[i] <= bus.writedata[7:0];
                end
            end
            if (bus.address == ADDR_CTRL) begin
                r_ctrl <= bus.writedata[1:0];
            end
            if (bus.address == ADDR_BLANK) begin
                r_blank <= bus.writedata[DIGITS-1:0];
            end
        end
    end

    // Scan FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Scan FSM next state. The counter runs through DEAD into ON without a
    // reset so a whole slot (dead time included) is exactly SCAN_DIV clocks.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        if (!w_en) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_idx_nxt   = 2'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_DEAD;
                end
                ST_DEAD: begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == DEAD_LAST) begin
                        w_state_nxt = ST_ON;
                    end
                end
                ST_ON: begin
                    if (r_cnt == SLOT_LAST) begin
                        w_cnt_nxt   = '0;
                        w_idx_nxt   = (r_idx == IDX_LAST) ? 2'd0 : r_idx + 2'd1;
                        w_state_nxt = ST_DEAD;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = 2'd0;
                end
            endcase
        end
    end

    // Pick the digit that will be shown after this edge.
    always_comb begin
        w_disp       = 8'h00;
        w_disp_blank = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_idx_nxt == 2'(i)) begin
                w_disp       = r_digit[i];
                w_disp_blank = r_blank[i];
            end
        end
    end

    keyled_seg_hexdec u_hexdec (
        .i_value (w_disp),
        .i_raw   (r_ctrl[CTRL_RAW]),
        .o_seg   (w_seg)
    );

    // Outputs are registered from the state being entered, so the pins track
    // the FSM state and any register write shows on the pins one clock later.
    always_comb begin
        w_seg_n_nxt = 8'hFF;
        w_dig_n_nxt = '1;
        if (w_state_nxt == ST_ON) begin
            w_seg_n_nxt = ~w_seg;
            if (!w_disp_blank) begin
                w_dig_n_nxt = ~(DIGITS'(1) << w_idx_nxt);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_seg_n <= 8'hFF;
            r_dig_n <= '1;
        end else begin
            r_seg_n <= w_seg_n_nxt;
            r_dig_n <= w_dig_n_nxt;
        end
    end

    assign seg_n = r_seg_n;
    assign dig_n = r_dig_n;

    // Read mux
    always_comb begin
        w_rdata = 32'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.address == ADDR_DIGIT0 + 3'(i)) begin
                w_rdata = {24'd0, r_digit[i]};
            end
        end
        case (bus.address)
            ADDR_CTRL:   w_rdata = {30'd0, r_ctrl};
            ADDR_BLANK:  w_rdata = {{(32-DIGITS){1'b0}}, r_blank};
            ADDR_STATUS: w_rdata = {29'd0, (r_state == ST_ON), r_idx};
            default:     ;
        endcase
    end

    assign bus.readdata = w_rdata;

endmodule

// File: tb/tb_keyled_seg_scan.sv
// tb/tb_keyled_seg_scan.sv - self-checking bench for keyled_seg_scan against a slot-time model
module tb_keyled_seg_scan;

    localparam int DIG = 4;
    localparam int SD  = 8;
    localparam int DC  = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] seg_n;
    logic [3:0] dig_n;

    keyled_seg_scan_if bus ();

    keyled_seg_scan #(
        .DIGITS   (DIG),
        .SCAN_DIV (SD),
        .DEAD_CYC (DC)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave),
        .seg_n   (seg_n),
        .dig_n   (dig_n)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;

    // Model: registers plus m_t = clocks since scanning became active (-1 = off).
    logic [7:0] m_digit [DIG];
    logic [1:0] m_ctrl;
    logic [3:0] m_blank;
    int         m_t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] hexseg(input logic [3:0] v);
        case (v)
            4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
            4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
            4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
            4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
        endcase
    endfunction

    function automatic bit model_on();
        return (m_t >= 0) && ((m_t % SD) >= DC);
    endfunction

    function automatic int model_idx();
        return (m_t >= 0) ? (m_t / SD) % DIG : 0;
    endfunction

    task automatic model_out(output logic [7:0] es, output logic [3:0] ed);
        logic [7:0] v;
        int d;
        es = 8'hFF;
        ed = 4'hF;
        if (model_on()) begin
            d  = model_idx();
            v  = m_digit[d];
            es = ~{v[7], (m_ctrl[1] ? v[6:0] : hexseg(v[3:0]))};
            if (!m_blank[d]) ed = ~(4'b0001 << d);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] a);
        if (a < 3'(DIG)) return {24'd0, m_digit[a[1:0]]};
        if (a == 3'd4) return {30'd0, m_ctrl};
        if (a == 3'd5) return {28'd0, m_blank};
        if (a == 3'd6) return {29'd0, model_on(), 2'(model_idx())};
        return 32'd0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DIG; i++) m_digit[i] = 8'h00;
        m_ctrl  = 2'b00;
        m_blank = 4'h0;
        m_t     = -1;
    endtask

    // One clock: optional write, model advance with pre-edge registers, output check.
    task automatic step(input bit wr, input logic [2:0] a, input logic [31:0] d);
        logic [7:0] es;
        logic [3:0] ed;
        bus.chipselect = wr;
        bus.write_n    = !wr;
        bus.address    = a;
        bus.writedata  = d;
        @(posedge clk);
        if (m_ctrl[0]) m_t++;
        else m_t = -1;
        model_out(es, ed);
        if (wr) begin
            if (a < 3'(DIG)) m_digit[a[1:0]] = d[7:0];
            else if (a == 3'd4) m_ctrl = d[1:0];
            else if (a == 3'd5) m_blank = d[3:0];
        end
        #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        check("seg_n", {24'd0, seg_n}, {24'd0, es});
        check("dig_n", {28'd0, dig_n}, {28'd0, ed});
    endtask

    task automatic rd_check(input logic [2:0] a);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        #1;
        check($sformatf("read_a%0d", a), bus.readdata, model_read(a));
        bus.chipselect = 1'b0;
    endtask

    initial begin
        logic [2:0]  ra;
        logic [31:0] rd;
        bit          found;

        bus.address    = 3'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'd0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("rst_seg_n", {24'd0, seg_n}, 32'h0000_00FF);
        check("rst_dig_n", {28'd0, dig_n}, 32'h0000_000F);
        reset_n = 1'b1;

        // Idle after reset
        for (int i = 0; i < 100; i++) step(1'b0, 3'd0, 32'd0);
        for (int a = 0; a < 8; a++) rd_check(3'(a));

        // Hex scan of 1,2,3,4
        for (int i = 0; i < DIG; i++) step(1'b1, 3'(i), 32'(i + 1));
        step(1'b1, 3'd4, 32'd1);
        for (int i = 0; i < 70; i++) begin
            step(1'b0, 3'd0, 32'd0);
            rd_check(3'd6);
        end

        // Raw mode with dp on digit 2
        step(1'b1, 3'd2, 32'hD5);
        step(1'b1, 3'd4, 32'd3);
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 3'd0, 32'd0);
            rd_check(3'd6);
        end

        // Blank digit 1
        step(1'b1, 3'd5, 32'h2);
        for (int i = 0; i < 40; i++) step(1'b0, 3'd0, 32'd0);
        step(1'b1, 3'd5, 32'h0);

        // Disable mid-ON of digit 3, then re-enable
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            if (model_on() && model_idx() == 3 && (m_t % SD) == 4) found = 1'b1;
            else step(1'b0, 3'd0, 32'd0);
        end
        check("reach_slot3", {31'd0, found}, 32'd1);
        step(1'b1, 3'd4, 32'd0);
        step(1'b0, 3'd0, 32'd0);
        rd_check(3'd6);
        step(1'b1, 3'd4, 32'd1);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 3'd0, 32'd0);
            rd_check(3'd6);
        end

        // Asynchronous reset while a digit is lit
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            if (model_on()) found = 1'b1;
            else step(1'b0, 3'd0, 32'd0);
        end
        check("reach_on", {31'd0, found}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_seg_n", {24'd0, seg_n}, 32'h0000_00FF);
        check("async_dig_n", {28'd0, dig_n}, 32'h0000_000F);
        model_reset();
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        for (int a = 0; a < 8; a++) rd_check(3'(a));

        // Randomized traffic
        step(1'b1, 3'd4, 32'd1);
        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                ra = 3'($urandom_range(0, 7));
                rd = $urandom;
                if (ra == 3'd4 && $urandom_range(0, 3) != 0) rd[0] = 1'b1;
                step(1'b1, ra, rd);
            end else begin
                step(1'b0, 3'd0, 32'd0);
            end
            rd_check(3'($urandom_range(0, 7)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
